// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding, register
// address width and the per-stage control bundle driven onto the pipeline registers.
package pipe_hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } hz_state_e;

    // One bit per pipeline-register control line, in IF -> WB order.
    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_write;
        logic memwb_bubble;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_INIT      = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                               idex_flush: 1'b1, exmem_write: 1'b0, memwb_bubble: 1'b1};
    localparam stage_ctrl_t CTRL_MEM_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                               idex_flush: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
    localparam stage_ctrl_t CTRL_LOAD_USE  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                               idex_flush: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};
    localparam stage_ctrl_t CTRL_BRANCH    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                               idex_flush: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};
    localparam stage_ctrl_t CTRL_NORMAL    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                               idex_flush: 1'b0, exmem_write: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once full.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline register sequencer: resolves memory waits, load-use hazards and taken
// branches into per-stage enable/flush/bubble controls, with stall statistics.
module pipe_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16,
    parameter int REG_AW   = pipe_hazard_ctrl_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [REG_AW-1:0] IFID_rs1_i,
    input  logic [REG_AW-1:0] IFID_rs2_i,
    input  logic              IDEX_MemRead_i,
    input  logic [REG_AW-1:0] IDEX_rd_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ready_i,
    output logic              PC_write_o,
    output logic              IFID_write_o,
    output logic              IFID_flush_o,
    output logic              IDEX_flush_o,
    output logic              EXMEM_write_o,
    output logic              MEMWB_bubble_o,
    output logic              dmem_valid_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic              mem_timeout_o
);
    import pipe_hazard_ctrl_pkg::*;

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    hz_state_e         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q, timeout_d;

    stage_ctrl_t ctrl;
    logic        in_init;
    logic        mem_stall;
    logic        load_use;
    logic        stall_cycle;
    logic        dmem_valid;

    always_comb begin
        in_init   = (state_q != ST_RUN) && (state_q != ST_MEM_WAIT);
        mem_stall = ((state_q == ST_RUN) && dmem_req_i && !dmem_ready_i) ||
                    ((state_q == ST_MEM_WAIT) && !dmem_ready_i);
        load_use  = IDEX_MemRead_i && (IDEX_rd_i != '0) &&
                    ((IDEX_rd_i == IFID_rs1_i) || (IDEX_rd_i == IFID_rs2_i));
    end

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        dmem_valid  = 1'b0;
        ctrl        = CTRL_NORMAL;
        stall_cycle = 1'b0;

        case (state_q)
            ST_RUN: begin
                dmem_valid = dmem_req_i;
                if (mem_stall) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                dmem_valid = 1'b1;
                if (dmem_ready_i) begin
                    state_d    = ST_RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != WAIT_MAX) begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_RUN;
                wait_cnt_d = '0;
            end
        endcase

        // Priority: INIT > mem stall > load-use > branch > normal.
        if (in_init) begin
            ctrl = CTRL_INIT;
        end else if (mem_stall) begin
            ctrl        = CTRL_MEM_STALL;
            stall_cycle = 1'b1;
        end else if (load_use) begin
            ctrl        = CTRL_LOAD_USE;
            stall_cycle = 1'b1;
        end else if (branch_taken_i) begin
            ctrl = CTRL_BRANCH;
        end

        // Timeout is sticky; the FSM keeps waiting regardless.
        if (mem_stall && (wait_cnt_d == WAIT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (stall_cycle),
        .clear_i (in_init),
        .cnt_o   (stall_cnt_o)
    );

    assign PC_write_o     = ctrl.pc_write;
    assign IFID_write_o   = ctrl.ifid_write;
    assign IFID_flush_o   = ctrl.ifid_flush;
    assign IDEX_flush_o   = ctrl.idex_flush;
    assign EXMEM_write_o  = ctrl.exmem_write;
    assign MEMWB_bubble_o = ctrl.memwb_bubble;
    assign dmem_valid_o   = dmem_valid;
    assign mem_timeout_o  = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MAX_WAIT=4, CNT_W=3; one line per cycle.
module tb_pipe_hazard_ctrl;

    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 3;
    localparam int REG_AW   = 5;

    // Control vector order: {PC_write, IFID_write, IFID_flush, IDEX_flush, EXMEM_write, MEMWB_bubble, dmem_valid}
    localparam logic [6:0] V_INIT  = 7'b0011010;
    localparam logic [6:0] V_NORM  = 7'b1100100;
    localparam logic [6:0] V_NORMV = 7'b1100101;
    localparam logic [6:0] V_LU    = 7'b0001100;
    localparam logic [6:0] V_BR    = 7'b1110100;
    localparam logic [6:0] V_BRV   = 7'b1110101;
    localparam logic [6:0] V_MS    = 7'b0000011;

    logic              clk;
    logic              rst_n;
    logic [REG_AW-1:0] rs1, rs2, rd;
    logic              mem_read, branch, req, ready;
    logic              pc_write, ifid_write, ifid_flush, idex_flush;
    logic              exmem_write, memwb_bubble, dmem_valid, timeout;
    logic [CNT_W-1:0]  stall_cnt;
    logic [6:0]        ctl;

    int n_chk = 0;
    int n_err = 0;

    pipe_hazard_ctrl #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W),
        .REG_AW   (REG_AW)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .IFID_rs1_i     (rs1),
        .IFID_rs2_i     (rs2),
        .IDEX_MemRead_i (mem_read),
        .IDEX_rd_i      (rd),
        .branch_taken_i (branch),
        .dmem_req_i     (req),
        .dmem_ready_i   (ready),
        .PC_write_o     (pc_write),
        .IFID_write_o   (ifid_write),
        .IFID_flush_o   (ifid_flush),
        .IDEX_flush_o   (idex_flush),
        .EXMEM_write_o  (exmem_write),
        .MEMWB_bubble_o (memwb_bubble),
        .dmem_valid_o   (dmem_valid),
        .stall_cnt_o    (stall_cnt),
        .mem_timeout_o  (timeout)
    );

    assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush, exmem_write, memwb_bubble, dmem_valid};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic [REG_AW-1:0] d, input logic [REG_AW-1:0] s1,
                         input logic [REG_AW-1:0] s2, input logic br, input logic rq, input logic rdy);
        mem_read = mr;
        rd       = d;
        rs1      = s1;
        rs2      = s2;
        branch   = br;
        req      = rq;
        ready    = rdy;
    endtask

    // Called at a negedge after driving inputs; checks mid-cycle, returns at next negedge.
    task automatic cyc(input string tag, input logic [6:0] ectl, input int ecnt, input logic eto);
        #1;
        $display("cyc %-10s ctl=%b cnt=%0d timeout=%b", tag, ctl, stall_cnt, timeout);
        check({tag, ".ctl"}, 32'(ctl), 32'(ectl));
        check({tag, ".cnt"}, 32'(stall_cnt), 32'(ecnt));
        check({tag, ".timeout"}, 32'(timeout), 32'(eto));
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        // Reset held: INIT controls even with a pending memory request.
        cyc("rst_hold", V_INIT, 0, 1'b0);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("init", V_INIT, 0, 1'b0);
        cyc("run", V_NORM, 0, 1'b0);

        // Load-use hazards
        drive(1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0); cyc("lu_rs2", V_LU, 0, 1'b0);
        drive(1'b0, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0); cyc("lu_clear", V_NORM, 1, 1'b0);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("lu_x0", V_NORM, 1, 1'b0);
        drive(1'b1, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0); cyc("lu_br", V_LU, 1, 1'b0);
        drive(1'b0, 5'd7, 5'd7, 5'd2, 1'b1, 1'b0, 1'b0); cyc("br", V_BR, 2, 1'b0);

        // Memory wait of three stall cycles
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("ms_run", V_MS, 2, 1'b0);
        cyc("ms_w1", V_MS, 3, 1'b0);
        cyc("ms_w2", V_MS, 4, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("ms_rel", V_NORMV, 5, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("ms_after", V_NORM, 5, 1'b0);

        // Branch and load-use are masked during a memory stall
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b0); cyc("br_ms0", V_MS, 5, 1'b0);
        drive(1'b1, 5'd4, 5'd4, 5'd0, 1'b1, 1'b1, 1'b0); cyc("br_ms1", V_MS, 6, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1); cyc("br_rel", V_BRV, 7, 1'b0);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("br_done", V_NORM, 7, 1'b0);

        // Timeout after MAX_WAIT wait cycles; counter already saturated at 7
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            cyc($sformatf("to_w%0d", k), V_MS, 7, (k >= 5) ? 1'b1 : 1'b0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); cyc("to_rel", V_NORMV, 7, 1'b1);
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("to_hold", V_NORM, 7, 1'b1);

        // Asynchronous reset in the middle of a wait
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0); cyc("rw_enter", V_MS, 7, 1'b1);
        #1;
        check("rw_in_wait.ctl", 32'(ctl), 32'(V_MS));
        rst_n = 1'b0;
        #1;
        $display("cyc %-10s ctl=%b cnt=%0d timeout=%b", "async_rst", ctl, stall_cnt, timeout);
        check("async_rst.ctl", 32'(ctl), 32'(V_INIT));
        check("async_rst.cnt", 32'(stall_cnt), 32'(0));
        check("async_rst.timeout", 32'(timeout), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        cyc("init2", V_INIT, 0, 1'b0);
        cyc("run2", V_NORM, 0, 1'b0);

        // Nine consecutive load-use stalls saturate the 3-bit counter at 7
        drive(1'b1, 5'd9, 5'd9, 5'd1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 9; k++) begin
            cyc($sformatf("sat%0d", k), V_LU, (k < 7) ? k : 7, 1'b0);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0); cyc("sat_hold", V_NORM, 7, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
